// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter state encoding and the
// round-robin index wrap helper.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_START = 2'd2,
        ARB_WAIT  = 2'd3
    } arb_state_t;

    // (base + off) mod n, assuming base < n and off < n
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req_valid bit at or above rr_ptr,
// wrapping around to bit 0.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_wrap(int'(rr_ptr), k, NUM_REQ)]) begin
                found = 1'b1;
                idx   = GRANT_W'(rr_wrap(int'(rr_ptr), k, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ
// byte streams. Optional packet lock via `UART_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = 2
) (
    input  logic                           hwclk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_byte,
    input  logic                           tx_done,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           busy
);

    arb_state_t         state;
    logic [GRANT_W-1:0] rr_ptr;
    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               grant_ok;
    logic [GRANT_W-1:0] grant_idx;
    logic               start_idle;
    logic [GRANT_W-1:0] ptr_next;

    rr_pick #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

`ifdef UART_ARB_PACKET_LOCK_EN
    logic locked;
    logic last_q;

    // While a packet is open only its owner may be granted.
    assign grant_ok  = locked ? req_valid[grant_id] : pick_found;
    assign grant_idx = locked ? grant_id : pick_idx;
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign grant_ok    = pick_found;
    assign grant_idx   = pick_idx;
`endif

    assign start_idle = (state == ARB_IDLE) && grant_ok && !reset;
    assign ptr_next   = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Pop is combinational so valid and ready meet in the grant cycle.
    always_comb begin
        req_ready = '0;
        if (start_idle)
            req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            tx_start <= 1'b0;
            tx_byte  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            locked   <= 1'b0;
            last_q   <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (start_idle) begin
                        grant_id <= grant_idx;
                        tx_byte  <= req_data[int'(grant_idx)*UART_BYTE_W +: UART_BYTE_W];
                        busy     <= 1'b1;
                        state    <= ARB_LOAD;
`ifdef UART_ARB_PACKET_LOCK_EN
                        last_q   <= req_last[grant_idx];
`endif
                    end
                end
                ARB_LOAD: begin
                    tx_start <= 1'b1;
                    state    <= ARB_START;
                end
                ARB_START: state <= ARB_WAIT;
                ARB_WAIT: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                        if (last_q) begin
                            rr_ptr <= ptr_next;
                            locked <= 1'b0;
                        end else begin
                            locked <= 1'b1;
                        end
`else
                        rr_ptr <= ptr_next;
`endif
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
